// File: rtl/alu_pkg.sv
// Shared definitions for the registered execute-stage ALU.
// Opcodes, flag bit positions and the sequencer state type.
package alu_pkg;

    localparam logic [3:0] OP_MOV = 4'b0001;
    localparam logic [3:0] OP_MVN = 4'b1001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_SBC = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110;
    localparam logic [3:0] OP_ORR = 4'b0111;
    localparam logic [3:0] OP_EOR = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam logic [3:0] OP_MLA = 4'b1011;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle op evaluation.
// Returns the result plus carry and overflow; N/Z are derived by the caller.
import alu_pkg::*;

module alu_core #(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       cmd,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] res,
    output logic             c,
    output logic             v
);

    logic [WIDTH-1:0] bb;
    logic             ci;
    logic [WIDTH:0]   sum;

    // One shared adder: subtraction is a + ~b + carry-in.
    always_comb begin
        bb = b;
        ci = 1'b0;
        case (cmd)
            OP_ADC: ci = c_in;
            OP_SUB: begin
                bb = ~b;
                ci = 1'b1;
            end
            OP_SBC: begin
                bb = ~b;
                ci = c_in;
            end
            default: ;
        endcase
        sum = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, ci};
    end

    // Result mux; logical and unknown codes leave C and V clear.
    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (cmd)
            OP_MOV: res = b;
            OP_MVN: res = ~b;
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[WIDTH-1] == bb[WIDTH-1])
                   && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: res = a & b;
            OP_ORR: res = a | b;
            OP_EOR: res = a ^ b;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_seq_unit.sv
// Registered execute-stage ALU with handshake, NZCV register
// and an iterative shift-add multiplier for MUL/MLA.
import alu_pkg::*;

module alu_seq_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       exe_cmd,
    input  logic             s_bit,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [WIDTH-1:0] op3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_res,
    output logic [3:0]       status_bits,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [3:0]       flags_q, flags_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s_q, s_d;

    logic [WIDTH-1:0] core_res;
    logic             core_c;
    logic             core_v;
    logic             accept;
    logic             is_mul;
    logic [WIDTH-1:0] acc_sum;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .cmd  (exe_cmd),
        .a    (op1),
        .b    (op2),
        .c_in (flags_q[FLAG_C]),
        .res  (core_res),
        .c    (core_c),
        .v    (core_v)
    );

    assign in_ready    = (state_q == ST_IDLE)
                      || (state_q == ST_DONE && out_ready);
    assign accept      = in_valid && in_ready && !flush;
    assign is_mul      = (exe_cmd == OP_MUL) || (exe_cmd == OP_MLA);
    assign acc_sum     = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign out_valid   = valid_q;
    assign alu_res     = res_q;
    assign status_bits = flags_q;
    assign busy        = (state_q == ST_MUL);

    // Next-state, datapath and flag update; flush overrides everything.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        res_d    = res_q;
        flags_d  = flags_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        s_d      = s_q;
        if (flush) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (state_q == ST_DONE && out_ready) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                    end
                    if (accept && is_mul) begin
                        acc_d    = (exe_cmd == OP_MLA) ? op3 : '0;
                        mcand_d  = op1;
                        mplier_d = op2;
                        cnt_d    = '0;
                        s_d      = s_bit;
                        valid_d  = 1'b0;
                        state_d  = ST_MUL;
                    end else if (accept) begin
                        res_d   = core_res;
                        valid_d = 1'b1;
                        state_d = ST_DONE;
                        if (s_bit) begin
                            flags_d = {core_res[WIDTH-1],
                                       core_res == '0,
                                       core_c, core_v};
                        end
                    end
                end
                ST_MUL: begin
                    acc_d    = acc_sum;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        res_d   = acc_sum;
                        valid_d = 1'b1;
                        state_d = ST_DONE;
                        if (s_q) begin
                            flags_d[FLAG_N] = acc_sum[WIDTH-1];
                            flags_d[FLAG_Z] = (acc_sum == '0);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            res_q    <= '0;
            flags_q  <= 4'b0000;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            s_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            res_q    <= res_d;
            flags_q  <= flags_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            s_q      <= s_d;
        end
    end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
Parametrised, registered execute-stage ALU. It is the next generation of the single-cycle combinational ALU.
- Adds a valid/ready handshake, a registered result and an internal NZCV flag register updated under the S bit.
- Adds a multi-cycle iterative MUL/MLA.
- Sits between the ID/EX pipeline register and the EX/MEM stage. The hazard unit stalls the pipeline through in_ready.

Parameters:
WIDTH, 32, datapath width in bits; legal values are 4 or more.
CNT_W, $clog2(WIDTH), width of the multiply iteration counter; derived, do not override.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous kill of the in-flight op and of any held result
in_valid  in  1  op presented
in_ready  out  1  unit can accept the op this cycle
exe_cmd  in  4  operation code
s_bit  in  1  update flags on completion
op1  in  WIDTH  first operand (Rn)
op2  in  WIDTH  second operand (shifter output)
op3  in  WIDTH  accumulate operand (MLA only)
out_valid  out  1  alu_res and status_bits are valid
out_ready  in  1  consumer takes the result
alu_res  out  WIDTH  registered result
status_bits  out  4  {N,Z,C,V} flag register (architectural flags)
busy  out  1  multiply in progress

Behaviour:
- Reset (async):
  - out_valid=0, alu_res=0, status_bits=4'b0000, busy=0.
  - State IDLE, so in_ready=1.
- States: IDLE, MUL, DONE.
- in_ready = (IDLE) or (DONE and out_ready). Accept = in_valid and in_ready.
- Opcodes, all arithmetic modulo 2^WIDTH:
  - 0001 mov: res = op2.
  - 1001 mvn: res = ~op2.
  - 0010 add: res = op1+op2. C = carry-out; V = signed overflow.
  - 0011 adc: res = op1+op2+flag C. C and V as for add.
  - 0100 sub: res = op1-op2. C = 1 when op1 >= op2 unsigned (no borrow); V = signed overflow.
  - 0101 sbc: res = op1-op2-(1-flag C). C = not borrow.
  - 0110 and, 0111 orr, 1000 eor: bitwise; C=0, V=0.
  - 1010 mul, 1011 mla: multi-cycle, see below.
  - Any other code: res = 0, C=0, V=0.
- N = res[WIDTH-1]; Z = (res == 0) for every op.
- Single-cycle ops: the accept edge loads alu_res, sets out_valid=1 and moves to DONE. Latency is 1 cycle.
- MUL/MLA:
  - Accept edge: acc <= (mla ? op3 : 0), mcand <= op1, mplier <= op2, cnt <= 0; go to MUL; busy=1.
  - Each MUL edge: if mplier[0] then acc += mcand. Then mcand <<= 1, mplier >>= 1, cnt++.
  - The edge with cnt == WIDTH-1 writes the final acc to alu_res, sets out_valid=1 and moves to DONE.
  - out_valid rises exactly WIDTH cycles after the accept edge. in_ready=0 while in MUL.
  - Result is the low WIDTH bits.
- Flags:
  - Written on the same edge that loads alu_res, and only if the latched s_bit=1.
  - MUL/MLA write N and Z only; C and V are kept.
  - A back-to-back op accepted in DONE sees the already-updated flags (no forwarding hazard).
- DONE:
  - alu_res and status_bits are held stable while out_ready=0.
  - out_ready=1 with no new accept: next edge clears out_valid and moves to IDLE.
  - out_ready=1 with a simultaneous accept: the new op is processed as if from IDLE, giving throughput 1 per cycle.
- Latched copies of exe_cmd, s_bit and operands are captured at accept. Inputs may change afterwards.
- flush:
  - Has priority over all transitions. Next state IDLE; out_valid=0; busy=0.
  - Flags and alu_res are not updated, including a MUL that would complete on that same edge.
  - An op offered in the same cycle as flush is not accepted; in_ready may be 1 but flush wins.
- rst mid-MUL: immediate return to reset values. No partial result is visible.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_MOV, OP_MVN, OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_ORR, OP_EOR, OP_MUL, OP_MLA);
  - flag bit indices N=3, Z=2, C=1, V=0;
  - the state enum typedef.
- One sub-module, alu_core: combinational, WIDTH-parametrised single-cycle op evaluation returning {res, c, v}.
- alu_seq_unit owns the FSM, the multiplier datapath, the flag register and the handshake.

Test Plan:
- Reset, then idle -> in_ready=1, out_valid=0, status_bits=0000, alu_res=0.
- ADD 0x7FFFFFFF+0x00000001, s_bit=1, out_ready=1 -> next cycle alu_res=0x80000000, status_bits=1001.
- SUB 5-5 (s=1), then back-to-back ADC 1+1 (s=0) -> first 0x00000000 with flags 0110; second 0x00000003, flags unchanged 0110.
- MUL 0x0000FFFF*0x00010001, s=1, starting flags 0011:
  - out_valid exactly 32 cycles after accept; busy=1 and in_ready=0 throughout.
  - alu_res=0xFFFFFFFF, status_bits=1011.
- MLA 3*4+0xFFFFFFF4 -> alu_res=0x00000000, Z=1.
- Backpressure: after ORR 0xF0|0x0F, hold out_ready=0 for 3 cycles -> alu_res=0x000000FF stable, in_ready=0. Then raise out_ready with MOV 0x12 offered -> accepted that cycle, next alu_res=0x00000012.
- flush on cycle 10 of a MUL (and separately rst) -> out_valid never rises, flags unchanged, in_ready=1 on the following cycle.
